mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 4:1 multiplexer datapath.
- Shares the mux between four requesters and drives the mux select lines addr0/addr1.
- Registers the selected input onto a single output with a valid flag.
- Sits between the four requesting sources and the downstream consumer of the muxed value.

---
 rtl/mux_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 mux, with a per-owner hold timeout
// and a registered data path. Define MUX_RR_ARBITER_LOCK_EN to add a lock input that suppresses timeout rotation.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic             lock,
`endif
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       grant,
    output logic             addr0,
    output logic             addr1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    localparam int unsigned HCNT_W = 8;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q, sel_d;
    logic [WIDTH-1:0]  out_q;
    logic              valid_q;
    logic              busy_q;

    logic              lock_w;
    logic [3:0]        others;
    logic [2:0]        pick_any;
    logic [2:0]        pick_oth;
    logic [2:0]        take;
    logic [WIDTH-1:0]  sel_data;

`ifdef MUX_RR_ARBITER_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // First set request scanning start, start+1, ... (mod 4); result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hcnt_d   = hcnt_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        take     = 3'b000;
        others   = req & ~(4'b0001 << sel_q);
        pick_any = rr_pick(req, ptr_q);
        pick_oth = rr_pick(others, sel_q + 2'd1);

        unique case (state_q)
            IDLE: begin
                if (pick_any[2]) take = pick_any;
            end
            GRANT: begin
                // The registered select doubles as the current owner index.
                if (!req[sel_q]) begin
                    if (pick_any[2]) begin
                        take = pick_any;
                    end else begin
                        grant_d = 4'b0000;
                        hcnt_d  = '0;
                        state_d = IDLE;
                    end
                end else if (lock_w) begin
                    if (hcnt_q != HOLD_LAST) hcnt_d = hcnt_q + HCNT_W'(1);
                end else if (hcnt_q == HOLD_LAST) begin
                    if (pick_oth[2]) take = pick_oth;
                    else             hcnt_d = '0;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (take[2]) begin
            state_d = GRANT;
            grant_d = 4'b0001 << take[1:0];
            sel_d   = take[1:0];
            ptr_d   = take[1:0] + 2'd1;
            hcnt_d  = '0;
        end
    end

    always_comb begin
        unique case (sel_q)
            2'd0:    sel_data = in0;
            2'd1:    sel_data = in1;
            2'd2:    sel_data = in2;
            default: sel_data = in3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            hcnt_q  <= '0;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= |grant_d;
            valid_q <= |grant_q;
            // Data follows the grant by one cycle, sampled through the select already registered.
            if (|grant_q) out_q <= sel_data;
        end
    end

    assign grant     = grant_q;
    assign addr0     = sel_q[0];
    assign addr1     = sel_q[1];
    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural owner/pointer/hold-count model.
module tb_mux_rr_arbiter;

    localparam int unsigned W    = 4;
    localparam int          MAXH = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic         lock;
    logic [W-1:0] din [4];
    logic [3:0]   grant;
    logic         addr0, addr1;
    logic [W-1:0] out;
    logic         out_valid;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .grant     (grant),
        .addr0     (addr0),
        .addr1     (addr1),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner index (-1 idle), next-scan pointer, cycles owned so far.
    int           m_owner, m_ptr, m_n;
    logic [1:0]   m_addr;
    logic [W-1:0] m_out;
    logic         m_valid;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_n = 0; m_addr = 2'd0; m_out = '0; m_valid = 1'b0;
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic model_give(input int w);
        m_owner = w; m_ptr = (w + 1) % 4; m_n = 1; m_addr = 2'(w);
    endtask

    task automatic model_edge(input logic [3:0] r, input logic lk);
        int w;
        logic [3:0] oth;
        m_valid = (m_owner >= 0);
        if (m_owner >= 0) m_out = din[m_addr];
        if (m_owner < 0 || !r[m_owner]) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_give(w);
            else        m_owner = -1;
        end else if (lk) begin
            if (m_n < MAXH) m_n++;
        end else if (m_n >= MAXH) begin
            oth = r;
            oth[m_owner] = 1'b0;
            w = pick(oth, m_owner + 1);
            if (w >= 0) model_give(w);
            else        m_n = 1;
        end else begin
            m_n++;
        end
    endtask

    function automatic logic [3:0] m_grant();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " grant"}, 32'(grant), 32'(m_grant()));
        chk({tag, " addr"},  32'({addr1, addr0}), 32'(m_addr));
        chk({tag, " out"},   32'(out), 32'(m_out));
        chk({tag, " valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, " busy"},  32'(busy), 32'(m_owner >= 0));
    endtask

    task automatic step(input logic [3:0] r, input logic lk);
        @(negedge clk);
        req = r; lock = lk;
        @(posedge clk);
        model_edge(r, lk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 4'b0000; lock = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         rst;
        logic [3:0]   req;
        logic [3:0]   g;
        logic [1:0]   a;
        logic         v;
        logic [W-1:0] o;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];

    logic [3:0] rreq;
    logic       rlk;

    initial begin
        // Data path and release-to-idle
        tv[0]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, 4'h0};
        tv[1]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 4'h5};
        tv[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 4'h5};
        tv[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 4'h5};
        // Fairness: each owner drops for one cycle, no idle bubble
        tv[4]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 4'h0};
        tv[5]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'hA};
        tv[6]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 4'hA};
        tv[7]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4'h5};
        tv[8]  = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 4'h5};
        tv[9]  = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 4'h3};
        tv[10] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 4'h3};
        tv[11] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 4'hC};
        tv[12] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 4'hC};
        // Skip and pointer wrap
        tv[13] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'hA};
        tv[14] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 4'hC};
        tv[15] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0, 4'hC};
        tv[16] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'h5};
        tv[17] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 4'hC};

        rst_n = 1'b0; req = 4'b0000; lock = 1'b0;
        din[0] = 4'hA; din[1] = 4'h5; din[2] = 4'h3; din[3] = 4'hC;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset addr",  32'({addr1, addr0}), 32'h0);
        chk("reset out",   32'(out), 32'h0);
        chk("reset valid", 32'(out_valid), 32'h0);
        chk("reset busy",  32'(busy), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (tv[i].rst) do_reset();
            step(tv[i].req, 1'b0);
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tv[i].g));
            chk($sformatf("vec%0d addr", i),  32'({addr1, addr0}), 32'(tv[i].a));
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(tv[i].v));
            chk($sformatf("vec%0d out", i),   32'(out), 32'(tv[i].o));
            chk($sformatf("vec%0d busy", i),  32'(busy), 32'(tv[i].g != 4'b0000));
        end

        // Asynchronous reset in the middle of a grant, then release straight into a request
        do_reset();
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst grant", 32'(grant), 32'h0);
        chk("midrst addr",  32'({addr1, addr0}), 32'h0);
        chk("midrst out",   32'(out), 32'h0);
        chk("midrst valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        req = 4'b0100; rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        model_edge(4'b0100, 1'b0);
        #1;
        chk("rel grant", 32'(grant), 32'b0100);
        chk("rel addr",  32'({addr1, addr0}), 32'd2);

        // Hold timeout: requester 0 owns exactly MAXH cycles while 2 waits
        do_reset();
        for (int i = 0; i < MAXH; i++) begin
            step(4'b0101, 1'b0);
            chk($sformatf("hold%0d grant", i), 32'(grant), 32'b0001);
        end
        step(4'b0101, 1'b0);
        chk("timeout grant", 32'(grant), 32'b0100);
        chk("timeout addr",  32'({addr1, addr0}), 32'd2);

        // Lone requester never rotates away
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0010, 1'b0);
            chk($sformatf("lone%0d grant", i), 32'(grant), 32'b0010);
        end

`ifdef MUX_RR_ARBITER_LOCK_EN
        do_reset();
        step(4'b0010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(4'b0011, 1'b1);
            chk($sformatf("lock%0d grant", i), 32'(grant), 32'b0010);
        end
        step(4'b0011, 1'b0);
        chk("unlock grant", 32'(grant), 32'b0001);
`endif

        // Randomized traffic against the model
        do_reset();
        rreq = 4'b0000;
        rlk  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                chk_model($sformatf("rnd%0d rst", i));
            end
            for (int k = 0; k < 4; k++) din[k] = W'($urandom);
            if ($urandom_range(0, 3) == 0) rreq = 4'($urandom);
`ifdef MUX_RR_ARBITER_LOCK_EN
            if ($urandom_range(0, 7) == 0) rlk = ~rlk;
`endif
            step(rreq, rlk);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
